// File: rtl/ccx_chunk_unit.sv
// ccx_chunk_unit: chunked custom-instruction execution unit.
// Operands arrive CHUNKSIZE bits per cycle, LSB chunk first. The unit
// computes ADD / XOR / MINU / POPCNT on the full 32-bit words and streams
// the result back LSB chunk first. resp_o marks the last result chunk.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for req_i; chunk 0 and sel_i captured on req_i
//   LOAD   | collecting operand chunks 1..NCH-1
//   CALC   | single cycle; full-word result written to res_q
//   OUT    | presenting result chunk[cnt] for NCH cycles
module ccx_chunk_unit #(
    parameter int CHUNKSIZE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [1:0]           sel_i,
    input  logic [CHUNKSIZE-1:0] rs_a_i,
    input  logic [CHUNKSIZE-1:0] rs_b_i,
    output logic [CHUNKSIZE-1:0] res_o,
    output logic                 resp_o,
    output logic                 busy_o
);

    localparam int NCH = 32 / CHUNKSIZE;
    localparam int CW  = $clog2(NCH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_XOR  = 2'b01;
    localparam logic [1:0] F_MINU = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic [31:0]   res_q, res_d;
    logic [31:0]   calc_res;

    function automatic logic [31:0] popcnt32(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Full-word function evaluation on the assembled operands
    always_comb begin
        calc_res = '0;
        case (sel_q)
            F_ADD:   calc_res = opa_q + opb_q;
            F_XOR:   calc_res = opa_q ^ opb_q;
            F_MINU:  calc_res = (opa_q < opb_q) ? opa_q : opb_q;
            default: calc_res = popcnt32(opa_q);
        endcase
    end

    // Next-state logic: operand capture, chunk counting, result latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    sel_d                  = sel_i;
                    opa_d                  = '0;
                    opb_d                  = '0;
                    opa_d[CHUNKSIZE-1:0]   = rs_a_i;
                    opb_d[CHUNKSIZE-1:0]   = rs_b_i;
                    cnt_d                  = CW'(1);
                    state_d                = S_LOAD;
                end
            end
            S_LOAD: begin
                opa_d[int'(cnt_q)*CHUNKSIZE +: CHUNKSIZE] = rs_a_i;
                opb_d[int'(cnt_q)*CHUNKSIZE +: CHUNKSIZE] = rs_b_i;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CALC: begin
                res_d   = calc_res;
                cnt_d   = '0;
                state_d = S_OUT;
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    // Outputs decoded purely from registered state, no input paths
    always_comb begin
        res_o  = '0;
        resp_o = 1'b0;
        busy_o = (state_q != S_IDLE);
        if (state_q == S_OUT) begin
            res_o  = res_q[int'(cnt_q)*CHUNKSIZE +: CHUNKSIZE];
            resp_o = (cnt_q == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_ccx_chunk_unit.sv
// Bench for ccx_chunk_unit: cycle-offset reference model plus literal checks.
module tb_ccx_chunk_unit;

    localparam int CS  = 4;
    localparam int NCH = 32 / CS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [1:0]    sel = 2'b00;
    logic [CS-1:0] rs_a = '0;
    logic [CS-1:0] rs_b = '0;
    logic [CS-1:0] res;
    logic          resp;
    logic          busy;

    logic          req1 = 1'b0;
    logic [0:0]    rs_a1 = '0;
    logic [0:0]    rs_b1 = '0;
    logic [0:0]    res1;
    logic          resp1;
    logic          busy1;

    int n_assert = 0;
    int n_fail   = 0;

    ccx_chunk_unit #(.CHUNKSIZE(CS)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .sel_i(sel),
        .rs_a_i(rs_a), .rs_b_i(rs_b), .res_o(res), .resp_o(resp), .busy_o(busy)
    );

    ccx_chunk_unit #(.CHUNKSIZE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .sel_i(sel),
        .rs_a_i(rs_a1), .rs_b_i(rs_b1), .res_o(res1), .resp_o(resp1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fn(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a ^ b;
            2'd2:    return (a < b) ? a : b;
            default: return 32'($countones(a));
        endcase
    endfunction

    // Reference model: tracks cycle offset from the accepted request.
    bit          m_active = 1'b0;
    int          m_cyc    = 0;
    logic [1:0]  m_sel    = '0;
    logic [31:0] m_a      = '0;
    logic [31:0] m_b      = '0;

    initial begin : model
        bit was;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
            end else begin
                was = m_active;
                if (m_active) begin
                    if (m_cyc < NCH) begin
                        m_a = m_a | (32'(rs_a) << (m_cyc * CS));
                        m_b = m_b | (32'(rs_b) << (m_cyc * CS));
                    end
                    m_cyc++;
                    if (m_cyc > 2 * NCH) m_active = 1'b0;
                end
                if (!was && req) begin
                    m_active = 1'b1;
                    m_cyc    = 1;
                    m_sel    = sel;
                    m_a      = 32'(rs_a);
                    m_b      = 32'(rs_b);
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    initial begin : compare
        logic [CS-1:0] e_res;
        forever begin
            @(negedge clk);
            e_res = '0;
            if (m_active && m_cyc > NCH)
                e_res = CS'(ref_fn(m_sel, m_a, m_b) >> ((m_cyc - NCH - 1) * CS));
            chk("cyc_res",  32'(res),  32'(e_res));
            chk("cyc_resp", 32'(resp), 32'(m_active && m_cyc == 2 * NCH));
            chk("cyc_busy", 32'(busy), 32'(m_active));
        end
    end

    // Issue one operation; optional stray req_i at cycles x1/x2 after t.
    task automatic run_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name,
                          input int x1 = -1, input int x2 = -1);
        logic [31:0] got;
        int nresp, resp_at, nbusy;
        got = '0; nresp = 0; resp_at = -1; nbusy = 0;
        req  = 1'b1;
        sel  = s;
        rs_a = CS'(a);
        rs_b = CS'(b);
        for (int j = 1; j <= 2 * NCH; j++) begin
            @(posedge clk); #1;
            req = (j == x1) || (j == x2);
            sel = 2'($urandom);
            if (j < NCH) begin
                rs_a = CS'(a >> (j * CS));
                rs_b = CS'(b >> (j * CS));
            end else begin
                rs_a = CS'($urandom);
                rs_b = CS'($urandom);
            end
            if (busy) nbusy++;
            if (resp) begin nresp++; resp_at = j; end
            if (j > NCH) got = got | (32'(res) << ((j - NCH - 1) * CS));
        end
        @(posedge clk); #1;
        req = 1'b0;
        chk({name, "_result"},  got, exp);
        chk({name, "_nresp"},   32'(nresp), 32'd1);
        chk({name, "_resp_at"}, 32'(resp_at), 32'(2 * NCH));
        chk({name, "_nbusy"},   32'(nbusy), 32'(2 * NCH));
        chk({name, "_idle"},    32'(busy), 32'd0);
    endtask

    initial begin : stim
        logic [31:0] a, b;
        logic [1:0]  s;
        int          nresp, resp_at;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res",  32'(res),  32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_ovf");
        run_op(2'd1, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, "xor");
        run_op(2'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "minu");
        run_op(2'd2, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, "minu_eq");
        run_op(2'd3, 32'hF0F0_F0F1, 32'hFFFF_FFFF, 32'h0000_0011, "popcnt");

        // Stray requests at t+3 and t+16, then a back-to-back one at t+17
        run_op(2'd0, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, "busy_req", 3, 2 * NCH);
        run_op(2'd1, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00, "b2b");

        // Reset asserted during t+5..t+6
        req = 1'b1; sel = 2'd0; rs_a = CS'(32'hFF); rs_b = CS'(32'hFF);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            req = 1'b0; rs_a = CS'($urandom); rs_b = CS'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_res",  32'(res),  32'd0);
        chk("abort_resp", 32'(resp), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        nresp = 0;
        for (int j = 0; j < 2 * NCH + 2; j++) begin
            @(posedge clk); #1;
            if (resp) nresp++;
        end
        chk("abort_no_resp", 32'(nresp), 32'd0);
        run_op(2'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, "add_after_rst");

        // Randomized operations with idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                rs_a = CS'($urandom); rs_b = CS'($urandom); sel = 2'($urandom);
                @(posedge clk); #1;
            end
            s = 2'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFF;
            run_op(s, a, b, ref_fn(s, a, b), "rand");
        end

        // CHUNKSIZE=1 instance: XOR stream 0,1,0,1,... and resp at t+64
        a = 32'hA5A5_A5A5; b = 32'h0F0F_0F0F;
        req1 = 1'b1; sel = 2'd1; rs_a1 = a[0]; rs_b1 = b[0];
        nresp = 0; resp_at = -1;
        for (int j = 1; j <= 64; j++) begin
            @(posedge clk); #1;
            req1 = 1'b0;
            if (j < 32) begin
                rs_a1 = a[j]; rs_b1 = b[j];
            end else begin
                rs_a1 = 1'($urandom); rs_b1 = 1'($urandom);
            end
            if (j > 32) chk("cs1_bit", 32'(res1), 32'((j - 33) % 2));
            if (resp1) begin nresp++; resp_at = j; end
        end
        chk("cs1_nresp",   32'(nresp), 32'd1);
        chk("cs1_resp_at", 32'(resp_at), 32'd64);
        @(posedge clk); #1;
        chk("cs1_idle", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
